// File: rtl/muldiv_ctrl.sv
//==============================================================================
// muldiv_ctrl : iterative MIPS multiply/divide sequencer owning HI/LO
// Revision    : 1.0
//==============================================================================
`default_nettype none

module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       op_func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_MUL  = 2'd1;
  localparam logic [1:0] c_ST_DIV  = 2'd2;
  localparam logic [1:0] c_ST_FIX  = 2'd3;

  localparam logic [5:0] c_FN_MFHI  = 6'd16;
  localparam logic [5:0] c_FN_MTHI  = 6'd17;
  localparam logic [5:0] c_FN_MFLO  = 6'd18;
  localparam logic [5:0] c_FN_MTLO  = 6'd19;
  localparam logic [5:0] c_FN_MULT  = 6'd24;
  localparam logic [5:0] c_FN_MULTU = 6'd25;
  localparam logic [5:0] c_FN_DIV   = 6'd26;
  localparam logic [5:0] c_FN_DIVU  = 6'd27;

  localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_is_div;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_func;
  logic               w_accept;
  logic               w_signed;
  logic [WIDTH-1:0]   w_rs_abs;
  logic [WIDTH-1:0]   w_rt_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_is_func = 1'b0;
    case (op_func)
      c_FN_MFHI, c_FN_MTHI, c_FN_MFLO, c_FN_MTLO,
      c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: w_is_func = 1'b1;
      default: w_is_func = 1'b0;
    endcase
  end

  assign w_accept = (r_state == c_ST_IDLE) && op_valid && !flush;
  assign w_signed = (op_func == c_FN_MULT) || (op_func == c_FN_DIV);
  // Signed operands are carried as unsigned magnitudes; 0x80..0 maps onto itself.
  assign w_rs_abs = (w_signed && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
  assign w_rt_abs = (w_signed && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;

  // Shift-add: accumulator holds {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: accumulator holds {remainder, dividend/quotient bits}.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_dz ? '1 : (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            case (op_func)
              c_FN_MTHI: r_hi <= rs_data;
              c_FN_MTLO: r_lo <= rs_data;
              c_FN_MULT, c_FN_MULTU: begin
                r_state  <= c_ST_MUL;
                r_acc    <= {{WIDTH{1'b0}}, w_rt_abs};
                r_b      <= w_rs_abs;
                r_neg_q  <= w_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                r_neg_r  <= 1'b0;
                r_dz     <= 1'b0;
                r_is_div <= 1'b0;
                r_cnt    <= c_CNT_INIT;
                r_busy   <= 1'b1;
              end
              c_FN_DIV, c_FN_DIVU: begin
                r_state  <= c_ST_DIV;
                r_acc    <= {{WIDTH{1'b0}}, w_rs_abs};
                r_b      <= w_rt_abs;
                r_neg_q  <= w_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                r_neg_r  <= w_signed && rs_data[WIDTH-1];
                r_dz     <= (rt_data == '0);
                r_is_div <= 1'b1;
                r_cnt    <= c_CNT_INIT;
                r_busy   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        c_ST_MUL, c_ST_DIV: begin
          if (flush) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= (r_state == c_ST_MUL) ? w_mul_next : w_div_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) r_state <= c_ST_FIX;
          end
        end
        default: begin
          // Completion cycle; a coincident flush squashes the HI/LO write.
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign stall      = op_valid && r_busy && w_is_func;
  assign hilo_rdata = (op_func == c_FN_MFHI) ? r_hi : r_lo;
  assign hi         = r_hi;
  assign lo         = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//==============================================================================
// tb_muldiv_ctrl : scoreboard bench for muldiv_ctrl
// Revision       : 1.0
//==============================================================================
`default_nettype none

module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [5:0]  op_func;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_func(op_func),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .stall(stall),
    .busy(busy), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   bcnt  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: each fall of busy is one completed (or squashed) operation.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      bcnt++;
    end else if (bcnt > 0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_completion: got busy fall with empty queue");
      end else begin
        e = q.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        if (e.cyc >= 0) check({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cyc));
      end
      bcnt = 0;
    end
  end

  task automatic expect_result(input string nm, input logic [31:0] ehi,
                               input logic [31:0] elo, input int cyc);
    exp_t e;
    e.name = nm;
    e.hi   = ehi;
    e.lo   = elo;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  // Presents one instruction for a single cycle; returns just after the accept edge.
  task automatic issue(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    op_valid = 1'b1;
    op_func  = fn;
    rs_data  = rs;
    rt_data  = rt;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy === 1'b1 && k < 100);
    if (k >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got busy still high after %0d cycles expected completion", nm, k);
    end
  endtask

  task automatic run_op(input string nm, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo);
    expect_result(nm, ehi, elo, 33);
    issue(fn, rs, rt);
    wait_done(nm);
  endtask

  initial begin
    int sc;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_func  = 6'd0;
    rs_data  = '0;
    rt_data  = '0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("multu_max",  6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",   6'd24, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_negneg",6'd24, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E);
    run_op("div_neg",    6'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negdvs", 6'd26, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_7_2",   6'd27, 32'd7,        32'd2,        32'h00000001, 32'h00000003);
    run_op("divu_by0",   6'd27, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    run_op("div_by0",    6'd26, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf",    6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MFLO held behind an in-flight MULTU
    expect_result("multu_3x4", 32'd0, 32'd12, 33);
    @(posedge clk);
    #1;
    op_valid = 1'b1;
    op_func  = 6'd25;
    rs_data  = 32'd3;
    rt_data  = 32'd4;
    @(posedge clk);
    #1;
    op_func  = 6'd18;
    sc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      sc++;
    end
    check("mflo_stall_cycles", 32'(sc), 32'd33);
    check("mflo_rdata", hilo_rdata, 32'd12);
    @(posedge clk);
    #1 op_valid = 1'b0;

    issue(6'd17, 32'h1234, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    issue(6'd19, 32'h1234, 32'd0);
    check("mtlo_lo", lo, 32'h1234);

    // flush during divide iterations
    expect_result("divu_flush", 32'h1234, 32'h1234, 11);
    issue(6'd27, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h1234);

    // flush in the FIX cycle suppresses the write
    expect_result("fix_flush", 32'h1234, 32'h1234, 33);
    issue(6'd25, 32'd2, 32'd3);
    repeat (32) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_done("fix_flush");

    // asynchronous reset mid-MULT
    expect_result("rst_mid", 32'd0, 32'd0, -1);
    issue(6'd24, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 expected earlier completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and MFHI, MFLO, using the standard MIPS Func encodings for the SPECIAL opcode.
- Sits beside the EX-stage ALU. It raises a stall to the pipeline controller when a HI/LO-class instruction arrives while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  EX stage holds a SPECIAL instruction destined for this unit
- op_func  in  6  Func field: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO; any other value is ignored
- rs_data  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
- rt_data  in  WIDTH  rt operand (multiplier/divisor)
- flush  in  1  squash the in-flight operation (exception or branch squash)
- stall  out  1  combinational; op_valid && busy && op_func is one of the 8 codes above
- busy  out  1  registered; operation in flight
- hilo_rdata  out  WIDTH  combinational; HI when op_func=MFHI, otherwise LO
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Reset: state=IDLE; busy=0; hi=lo=0; counter=0; internal accumulators=0. Reset is asynchronous and overrides everything, including mid-operation (HI/LO become 0).
- Acceptance: an instruction is accepted only when state=IDLE && op_valid && !flush.
  - Anything presented while busy is not accepted. stall holds the pipeline, so the same instruction is re-presented.
- MTHI/MTLO: on the accept edge, hi<=rs_data or lo<=rs_data; the unit stays IDLE (1-cycle).
- MFHI/MFLO: purely combinational through hilo_rdata when not stalled. No state change.
- MULT/MULTU/DIV/DIVU: on the accept edge, latch operands, record signedness and the sign fix-up flags, go to MUL or DIV, set counter=WIDTH-1, and set busy=1.
  - Signed ops latch |rs| and |rt| as unsigned WIDTH-bit magnitudes.
- States: IDLE -> MUL|DIV -> FIX -> IDLE.
  - MUL: radix-2 shift-add, one bit per cycle, over a 2*WIDTH-bit accumulator.
  - DIV: restoring divide, one quotient bit per cycle.
  - counter decrements each cycle; at counter=0 go to FIX.
  - FIX (1 cycle): apply the sign correction, write hi/lo, clear busy, return to IDLE.
- Latency: busy is high for exactly WIDTH+1 cycles after the accept edge (33 at default). New HI/LO is visible the cycle busy falls.
- Sign rules for signed ops:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
- Result mapping: multiply gives HI=upper word, LO=lower word. Divide gives LO=quotient, HI=remainder.
- Divide by zero: no trap; completes in normal latency with LO=all ones and HI=rs_data. This holds for both DIV and DIVU.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- flush while busy: the next edge returns to IDLE, busy=0, and hi/lo keep their pre-op values. flush in IDLE blocks acceptance that cycle.
- Simultaneous events:
  - flush in the FIX cycle wins; no HI/LO write.
  - A new op presented in the FIX cycle is stalled. It is accepted the following cycle and sees the updated HI/LO.
- Counter and accumulators are don't-care in IDLE but must not produce X on outputs.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE lo=0x00000001.
- MULT rs=0xFFFFFFFD(-3) rt=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9(-7) rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU rs=7 rt=2 -> lo=3 hi=1.
- DIVU rs=5 rt=0 -> lo=0xFFFFFFFF hi=5. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000 hi=0.
- MULTU 3*4 then MFLO held valid -> stall=1 for 33 cycles; first unstalled cycle gives hilo_rdata=12. MTHI rs=0x1234 in IDLE -> hi=0x1234 next cycle.
- With hi=lo=0x1234, start DIVU and assert flush at iteration 10 -> busy=0 next cycle, hi=lo=0x1234 unchanged. Assert rst_n=0 mid-MULT -> busy=0, hi=lo=0 immediately.
